glb_bus_tx: RTL and testbench

GLB_BUS_TX -- requirements
Module: glb_bus_tx

---
 rtl/glb_pkg.sv | 22 ++
 rtl/glb_tx_fifo.sv | 63 ++++++
 rtl/glb_bus_tx.sv | 120 ++++++++++++
 tb/tb_glb_bus_tx.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/glb_pkg.sv
// Shared types for the global-buffer bus transmitter: FSM states, FIFO entry
// layout and the default payload/tag/FIFO sizes.
package glb_pkg;

  localparam int GLB_DATA_W     = 16;
  localparam int GLB_ID_W       = 4;
  localparam int GLB_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } glb_state_e;

  typedef struct packed {
    logic [GLB_DATA_W-1:0] data;
    logic [GLB_ID_W-1:0]   row_id;
    logic [GLB_ID_W-1:0]   col_id;
    logic                  last;
  } glb_entry_t;

endpackage

// File: rtl/glb_tx_fifo.sv
// Single-clock skid FIFO between the buffer read side and the multicast bus.
// Full/empty come from an occupancy count; pointers wrap naturally (DEPTH is 2^n).
module glb_tx_fifo
  import glb_pkg::*;
#(
  parameter int DEPTH = GLB_FIFO_DEPTH
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       push_i,
  input  glb_entry_t wdata_i,
  input  logic       pop_i,
  output glb_entry_t rdata_o,
  output logic       full_o,
  output logic       empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  glb_entry_t       mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             push_ok, pop_ok;

  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;
  assign rdata_o = mem_q[rptr_q];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (push_ok) wptr_d = wptr_q + 1'b1;
    if (pop_ok)  rptr_d = rptr_q + 1'b1;
    // Simultaneous push and pop leaves occupancy unchanged.
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/glb_bus_tx.sv
// Streams one pass of pass_len beats from the global buffer onto the multicast
// bus through a skid FIFO; tags the final beat and pulses done once it leaves.
module glb_bus_tx
  import glb_pkg::*;
#(
  parameter int DATA_WIDTH = GLB_DATA_W,
  parameter int ID_WIDTH   = GLB_ID_W,
  parameter int FIFO_DEPTH = GLB_FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic [15:0]           pass_len,
  input  logic                  src_valid,
  output logic                  src_ready,
  input  logic [DATA_WIDTH-1:0] src_data,
  input  logic [ID_WIDTH-1:0]   src_row_id,
  input  logic [ID_WIDTH-1:0]   src_col_id,
  output logic                  bus_valid,
  input  logic                  bus_ready,
  output logic [DATA_WIDTH-1:0] bus_data,
  output logic [ID_WIDTH-1:0]   bus_row_id,
  output logic [ID_WIDTH-1:0]   bus_col_id,
  output logic                  bus_last,
  output logic                  busy,
  output logic                  done
);

  glb_state_e  state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [15:0] acc_q, acc_d;
  logic [15:0] snd_q, snd_d;
  logic        done_q, done_d;
  logic        fifo_full, fifo_empty;
  logic        push, pop;
  glb_entry_t  wentry, hentry;

  assign src_ready = (state_q == ST_RUN) & ~fifo_full;
  assign push      = src_valid & src_ready;
  assign bus_valid = ~fifo_empty;
  assign pop       = bus_valid & bus_ready;

  assign wentry = '{data:   src_data,
                    row_id: src_row_id,
                    col_id: src_col_id,
                    last:   (acc_q == len_q - 16'd1)};

  glb_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .push_i  (push),
    .wdata_i (wentry),
    .pop_i   (pop),
    .rdata_o (hentry),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Gate bus_last so it reads 0 whenever the (unreset) head slot is not valid.
  assign bus_data   = hentry.data;
  assign bus_row_id = hentry.row_id;
  assign bus_col_id = hentry.col_id;
  assign bus_last   = bus_valid & hentry.last;
  assign busy       = (state_q != ST_IDLE);
  assign done       = done_q;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    acc_d   = acc_q;
    snd_d   = snd_q;
    done_d  = 1'b0;
    if (pop && (snd_q != len_q)) snd_d = snd_q + 16'd1;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (pass_len != 16'd0) begin
            state_d = ST_RUN;
            len_d   = pass_len;
            acc_d   = 16'd0;
            snd_d   = 16'd0;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (push) begin
          acc_d = acc_q + 16'd1;
          if (wentry.last) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // The tagged beat is always the last one in the FIFO, so it leaves empty.
        if (pop && hentry.last) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      len_q   <= 16'd0;
      acc_q   <= 16'd0;
      snd_q   <= 16'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      acc_q   <= acc_d;
      snd_q   <= snd_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_glb_bus_tx.sv
// Scoreboard bench for glb_bus_tx: accepted beats queue their expected bus
// image; a negedge monitor pops and compares every beat the bus delivers.
module tb_glb_bus_tx;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start;
  logic [15:0] pass_len;
  logic        src_valid;
  logic        src_ready;
  logic [15:0] src_data;
  logic [3:0]  src_row_id;
  logic [3:0]  src_col_id;
  logic        bus_valid;
  logic        bus_ready;
  logic [15:0] bus_data;
  logic [3:0]  bus_row_id;
  logic [3:0]  bus_col_id;
  logic        bus_last;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  glb_bus_tx #(.DATA_WIDTH(16), .ID_WIDTH(4), .FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .start      (start),
    .pass_len   (pass_len),
    .src_valid  (src_valid),
    .src_ready  (src_ready),
    .src_data   (src_data),
    .src_row_id (src_row_id),
    .src_col_id (src_col_id),
    .bus_valid  (bus_valid),
    .bus_ready  (bus_ready),
    .bus_data   (bus_data),
    .bus_row_id (bus_row_id),
    .bus_col_id (bus_col_id),
    .bus_last   (bus_last),
    .busy       (busy),
    .done       (done)
  );

  typedef struct {
    logic [15:0] d;
    logic [3:0]  r;
    logic [3:0]  c;
    logic        l;
  } exp_t;

  exp_t        sb_q[$];
  int          checks   = 0;
  int          fails    = 0;
  int          pop_cnt  = 0;
  int          acc_cnt  = 0;
  int          both_cnt = 0;
  logic        done_exp_q = 1'b0;
  logic        t3_end;
  logic [15:0] vec [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: a beat is taken at the next posedge when valid&ready at negedge.
  always @(negedge clk) begin : mon
    exp_t e;
    logic nxt;
    if (!rstn) begin
      done_exp_q = 1'b0;
    end else begin
      chk("done", 32'(done), 32'(done_exp_q));
      nxt = start && !busy && (pass_len == 16'd0);
      if (src_valid && src_ready && bus_valid && bus_ready) both_cnt++;
      if (bus_valid && bus_ready) begin
        if (sb_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL sb_underflow: bus beat 0x%0h with no expected entry at %0t", bus_data, $time);
        end else begin
          e = sb_q.pop_front();
          chk("bus_data", 32'(bus_data), 32'(e.d));
          chk("bus_row", 32'(bus_row_id), 32'(e.r));
          chk("bus_col", 32'(bus_col_id), 32'(e.c));
          chk("bus_last", 32'(bus_last), 32'(e.l));
          pop_cnt++;
          if (e.l) nxt = 1'b1;
        end
      end
      done_exp_q = nxt;
    end
  end

  task automatic do_start(input logic [15:0] len);
    @(posedge clk); #1;
    start    = 1'b1;
    pass_len = len;
    @(posedge clk); #1;
    start    = 1'b0;
  endtask

  task automatic run_src(input int n, input int len, input logic [3:0] r, input logic [3:0] c);
    int budget;
    for (int i = 0; i < n; i++) begin
      src_valid  = 1'b1;
      src_data   = vec[i];
      src_row_id = r;
      src_col_id = c;
      budget = 0;
      do begin
        @(negedge clk);
        budget++;
      end while (!src_ready && budget < 300);
      if (!src_ready) begin
        checks++;
        fails++;
        $display("FAIL src_timeout: beat %0d not accepted, src_ready=%0b expected 1", i, src_ready);
        src_valid = 1'b0;
        return;
      end
      sb_q.push_back('{d: vec[i], r: r, c: c, l: (i == len - 1)});
      acc_cnt++;
      @(posedge clk); #1;
    end
    src_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (done !== 1'b1 && n < 400);
    if (done !== 1'b1) begin
      checks++;
      fails++;
      $display("FAIL %s_done_timeout: done=%0b expected 1 within 400 cycles", name, done);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int base, abase, bbase, k;
    rstn = 1'b0; start = 1'b0; pass_len = 16'd0; src_valid = 1'b0;
    src_data = 16'd0; src_row_id = 4'd0; src_col_id = 4'd0; bus_ready = 1'b0;
    t3_end = 1'b0;
    #12;
    chk("rst_src_ready", 32'(src_ready), 32'd0);
    chk("rst_bus_valid", 32'(bus_valid), 32'd0);
    chk("rst_bus_last", 32'(bus_last), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    @(posedge clk); #1;
    rstn = 1'b1;

    // Pass of 3 with the bus always ready; first beat seen one cycle after accept.
    vec[0] = 16'h0011; vec[1] = 16'h0022; vec[2] = 16'h0033;
    bus_ready = 1'b1;
    base = pop_cnt;
    do_start(16'd3);
    chk("t1_busy", 32'(busy), 32'd1);
    fork
      run_src(3, 3, 4'd1, 4'd2);
      begin
        k = 0;
        do begin
          @(negedge clk);
          k++;
        end while (!(src_valid && src_ready) && k < 50);
        @(negedge clk);
        chk("t1_lat_valid", 32'(bus_valid), 32'd1);
        chk("t1_lat_data", 32'(bus_data), 32'h11);
      end
    join
    wait_done("t1");
    chk("t1_pops", 32'(pop_cnt - base), 32'd3);
    chk("t1_sb_empty", 32'(sb_q.size()), 32'd0);
    chk("t1_idle", 32'(busy), 32'd0);

    // Pass of 8 against a stalled bus: FIFO fills at 4, head holds, then drains.
    for (int i = 0; i < 8; i++) vec[i] = 16'(16'hA0 + i);
    bus_ready = 1'b0;
    base  = pop_cnt;
    abase = acc_cnt;
    do_start(16'd8);
    fork
      run_src(8, 8, 4'd3, 4'd4);
    join_none
    repeat (10) @(negedge clk);
    chk("t2_accepted", 32'(acc_cnt - abase), 32'd4);
    chk("t2_src_ready", 32'(src_ready), 32'd0);
    chk("t2_bus_valid", 32'(bus_valid), 32'd1);
    chk("t2_head_data", 32'(bus_data), 32'hA0);
    repeat (3) @(negedge clk);
    chk("t2_hold_data", 32'(bus_data), 32'hA0);
    chk("t2_hold_row", 32'(bus_row_id), 32'd3);
    chk("t2_hold_last", 32'(bus_last), 32'd0);
    @(posedge clk); #1;
    bus_ready = 1'b1;
    wait_done("t2");
    chk("t2_pops", 32'(pop_cnt - base), 32'd8);
    chk("t2_sb_empty", 32'(sb_q.size()), 32'd0);

    // Pass of 6 with bus_ready toggling every cycle.
    for (int i = 0; i < 6; i++) vec[i] = 16'(16'h51 + i);
    bus_ready = 1'b0;
    base  = pop_cnt;
    bbase = both_cnt;
    t3_end = 1'b0;
    do_start(16'd6);
    fork
      run_src(6, 6, 4'd5, 4'd6);
      begin
        for (int i = 0; i < 80 && !t3_end; i++) begin
          bus_ready = ~bus_ready;
          @(posedge clk); #1;
        end
        bus_ready = 1'b1;
      end
      begin
        wait_done("t3");
        t3_end = 1'b1;
      end
    join
    chk("t3_pops", 32'(pop_cnt - base), 32'd6);
    chk("t3_simul", 32'((both_cnt - bbase) != 0), 32'd1);
    chk("t3_sb_empty", 32'(sb_q.size()), 32'd0);

    // Zero-length pass: nothing offered or sent, done on the next cycle.
    do_start(16'd0);
    @(negedge clk);
    chk("t4_done", 32'(done), 32'd1);
    for (int i = 0; i < 3; i++) begin
      chk("t4_src_ready", 32'(src_ready), 32'd0);
      chk("t4_bus_valid", 32'(bus_valid), 32'd0);
      @(negedge clk);
    end

    // Reset after 2 of 5 beats, then a clean pass of 2.
    for (int i = 0; i < 5; i++) vec[i] = 16'(16'h71 + i);
    bus_ready = 1'b0;
    do_start(16'd5);
    run_src(2, 5, 4'd7, 4'd8);
    chk("t5_pre_valid", 32'(bus_valid), 32'd1);
    #3;
    rstn = 1'b0;
    #1;
    chk("t5_src_ready", 32'(src_ready), 32'd0);
    chk("t5_bus_valid", 32'(bus_valid), 32'd0);
    chk("t5_bus_last", 32'(bus_last), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_done", 32'(done), 32'd0);
    sb_q.delete();
    @(posedge clk); #1;
    rstn = 1'b1;
    repeat (3) @(negedge clk);
    chk("t5_no_done", 32'(done), 32'd0);
    vec[0] = 16'h0081; vec[1] = 16'h0082;
    bus_ready = 1'b1;
    base = pop_cnt;
    do_start(16'd2);
    run_src(2, 2, 4'd9, 4'd10);
    wait_done("t5");
    chk("t5_pops", 32'(pop_cnt - base), 32'd2);

    // A start pulse during RUN must not change the latched length.
    for (int i = 0; i < 4; i++) vec[i] = 16'(16'hC1 + i);
    bus_ready = 1'b1;
    base = pop_cnt;
    do_start(16'd4);
    fork
      run_src(4, 4, 4'd11, 4'd12);
      begin
        @(posedge clk); #1;
        start    = 1'b1;
        pass_len = 16'd2;
        @(posedge clk); #1;
        start    = 1'b0;
      end
    join
    wait_done("t6");
    chk("t6_pops", 32'(pop_cnt - base), 32'd4);
    chk("t6_sb_empty", 32'(sb_q.size()), 32'd0);
    chk("t6_idle", 32'(busy), 32'd0);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
